// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU (priority) and a debug/DMA requester,
// with starvation protection for B and a response timeout that aborts with bus_err_o.
module dmem_arbiter #(
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_data_i,
  output logic        a_stall_o,
  output logic        a_done_o,
  output logic [31:0] a_data_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_data_i,
  output logic        b_ack_o,
  output logic [31:0] b_data_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_data_i,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [3:0]  starve_cnt;
  logic [7:0]  tmo_cnt;
  logic        a_win, tmo, fin;
  logic [31:0] rdata;
  assign a_win     = a_req_i && !(b_req_i && starve_cnt == SMAX);
  assign tmo       = tmo_cnt == TMAX;
  assign fin       = m_ack_i || tmo;
  // an ack coinciding with the timeout wins, so the timeout only zeroes data when no ack is present
  assign rdata     = m_ack_i ? m_data_i : 32'h0;
  assign a_stall_o = a_req_i & ~a_done_o;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      m_req_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_addr_o   <= '0;
      m_data_o   <= '0;
      a_done_o   <= 1'b0;
      a_data_o   <= '0;
      b_ack_o    <= 1'b0;
      b_data_o   <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      a_done_o  <= 1'b0;
      b_ack_o   <= 1'b0;
      bus_err_o <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        if (a_win) begin
          state    <= GNT_A;
          m_req_o  <= 1'b1;
          m_we_o   <= a_we_i;
          m_addr_o <= a_addr_i;
          m_data_o <= a_data_i;
          if (b_req_i && starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
        end else if (b_req_i) begin
          state      <= GNT_B;
          m_req_o    <= 1'b1;
          m_we_o     <= b_we_i;
          m_addr_o   <= b_addr_i;
          m_data_o   <= b_data_i;
          starve_cnt <= '0;
        end
      end else if (fin) begin
        state     <= IDLE;
        m_req_o   <= 1'b0;
        bus_err_o <= !m_ack_i;
        if (state == GNT_A) begin
          a_done_o <= 1'b1;
          a_data_o <= rdata;
        end else begin
          b_ack_o  <= 1'b1;
          b_data_o <= rdata;
        end
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven transactions, directed arbitration/reset sequences,
// and a randomized run checked against a transaction-level arbitration model.
module tb_dmem_arbiter;
  logic        clk = 0, rst = 0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0, m_ack = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0, m_rdata = 0;
  logic        a_stall, a_done, b_ack, m_req, m_we, bus_err;
  logic [31:0] a_rdata, b_rdata, m_addr, m_wdata;
  int          checks = 0, failures = 0;

  dmem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_wdata),
    .a_stall_o(a_stall), .a_done_o(a_done), .a_data_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_wdata),
    .b_ack_o(b_ack), .b_data_o(b_rdata),
    .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr), .m_data_o(m_wdata),
    .m_ack_i(m_ack), .m_data_i(m_rdata), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr, wdata, rdata, exp_data;
    int          d;
    bit          drop;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    bit seen;
    if (!v.port) begin
      a_req = 1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end else begin
      b_req = 1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end
    step();
    chk("grant_m_req", m_req, 1);
    chk("grant_m_we", m_we, v.we);
    chk("grant_m_addr", m_addr, v.addr);
    chk("grant_m_data", m_wdata, v.wdata);
    if (!v.port && !v.drop) chk("stall_wait", a_stall, 1);
    if (v.drop) begin a_req = 0; b_req = 0; end
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 300) begin
      cyc++;
      m_ack = (cyc == v.d);
      m_rdata = (cyc == v.d) ? v.rdata : 32'hDEADBEEF;
      step();
      m_ack = 0;
      seen = v.port ? b_ack : a_done;
    end
    chk("done_cycle", cyc, v.exp_cyc);
    chk("done_data", v.port ? b_rdata : a_rdata, v.exp_data);
    chk("done_bus_err", bus_err, v.exp_err);
    chk("done_m_req_low", m_req, 0);
    if (!v.port && !v.drop) chk("stall_done", a_stall, 0);
    a_req = 0;
    b_req = 0;
    step();
    chk("done_one_pulse", a_done | b_ack | bus_err, 0);
  endtask

  initial begin
    int pulses, w, g, exp_port, gport, delay, wcnt, st, e;
    bit ar, br, prev_mreq;
    logic [31:0] exp_rd;
    tbl[0] = '{0, 0, 32'h100, 32'h0,      32'hCAFEF00D, 32'hCAFEF00D, 3,  0, 0, 3};
    tbl[1] = '{1, 1, 32'h40,  32'h12345678, 32'h00005A5A, 32'h00005A5A, 1, 0, 0, 1};
    tbl[2] = '{0, 0, 32'h104, 32'h0,      32'h0,        32'h0,        0,  0, 1, 64};
    tbl[3] = '{0, 0, 32'h108, 32'h0,      32'h11112222, 32'h11112222, 1,  0, 0, 1};
    tbl[4] = '{1, 0, 32'h44,  32'h0,      32'h0BADF00D, 32'h0BADF00D, 64, 0, 0, 64};
    tbl[5] = '{1, 0, 32'h48,  32'h0,      32'h0,        32'h0,        0,  0, 1, 64};
    tbl[6] = '{0, 1, 32'h10C, 32'h77,     32'h33,       32'h33,       2,  1, 0, 2};
    tbl[7] = '{1, 0, 32'h4C,  32'h0,      32'h44,       32'h44,       4,  1, 0, 4};

    repeat (3) @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_a_data", a_rdata, 0);
    rst = 1;
    step();

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // simultaneous requests: A first, bubble, then B exactly once
    a_req = 1; a_addr = 32'h200; a_we = 0;
    b_req = 1; b_addr = 32'h300; b_we = 0;
    step();
    chk("both_a_first", m_addr, 32'h200);
    m_ack = 1; m_rdata = 32'hA0A0A0A0;
    step();
    m_ack = 0;
    chk("both_a_done", a_done, 1);
    chk("both_bubble", m_req, 0);
    a_req = 0;
    step();
    chk("both_b_granted", m_req, 1);
    chk("both_b_addr", m_addr, 32'h300);
    m_ack = 1; m_rdata = 32'hB0B0B0B0;
    step();
    m_ack = 0;
    pulses = b_ack;
    chk("both_b_data", b_rdata, 32'hB0B0B0B0);
    b_req = 0;
    repeat (3) begin step(); pulses += b_ack; end
    chk("both_b_pulses", pulses, 1);

    // starvation: A continuous, B held -> AAAAB then A again
    a_req = 1; a_addr = 32'h500;
    b_req = 1; b_addr = 32'h600;
    for (g = 0; g < 6; g++) begin
      w = 0;
      while (!m_req && w < 10) begin step(); w++; end
      exp_port = (g == 4) ? 1 : 0;
      chk($sformatf("starve_grant%0d", g), m_addr, exp_port ? 32'h600 : 32'h500);
      m_ack = 1; m_rdata = g;
      step();
      m_ack = 0;
      chk($sformatf("starve_done%0d", g), exp_port ? b_ack : a_done, 1);
      step();
    end
    a_req = 0; b_req = 0;
    repeat (3) step();

    // async reset during GNT_B drops the transaction silently
    b_req = 1; b_addr = 32'h80; b_we = 0;
    step();
    chk("rstb_granted", m_req, 1);
    #2 rst = 0;
    #1;
    chk("rstb_m_req_async", m_req, 0);
    chk("rstb_m_addr_async", m_addr, 0);
    b_req = 0;
    m_ack = 1;
    pulses = 0;
    repeat (3) begin step(); pulses += b_ack; end
    m_ack = 0;
    chk("rstb_no_ack", pulses, 0);
    rst = 1;
    step();
    run_vec('{1, 0, 32'h84, 32'h0, 32'h5555AAAA, 32'h5555AAAA, 2, 0, 0, 2});

    // randomized traffic against a transaction-level model
    gport = -1; st = 0; prev_mreq = 0; delay = 0; wcnt = 0; exp_rd = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ar = a_req;
      br = b_req;
      chk("rnd_stall", a_stall, ar & ~a_done);
      if (a_done || b_ack) begin
        if (gport < 0) chk("rnd_spurious_done", 1, 0);
        else begin
          chk("rnd_done_port", b_ack, gport);
          chk("rnd_done_data", gport ? b_rdata : a_rdata, exp_rd);
          chk("rnd_done_err", bus_err, 0);
          if (gport == 1) b_req = 0; else a_req = 0;
          gport = -1;
        end
      end
      if (m_req && !prev_mreq) begin
        e = (ar && !(br && st == 4)) ? 0 : (br ? 1 : -1);
        if (e < 0) chk("rnd_grant_unrequested", 1, 0);
        else begin
          chk("rnd_grant_addr", m_addr, e ? b_addr : a_addr);
          chk("rnd_grant_we", m_we, e ? b_we : a_we);
          chk("rnd_grant_data", m_wdata, e ? b_wdata : a_wdata);
          st = e ? 0 : (br ? (st < 4 ? st + 1 : 4) : st);
          gport = e;
          delay = $urandom_range(1, 5);
          wcnt = 0;
        end
      end
      prev_mreq = m_req;
      m_ack = 0;
      if (gport >= 0) begin
        wcnt++;
        if (wcnt == delay) begin
          exp_rd = $urandom;
          m_ack = 1;
          m_rdata = exp_rd;
        end else if (wcnt > delay + 2) begin
          chk("rnd_done_missing", 0, 1);
          gport = -1;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        m_ack = 1;
        m_rdata = $urandom;
      end
      if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1; a_we = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
      end
      if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1; b_we = 1'($urandom); b_addr = $urandom; b_wdata = $urandom;
      end
    end
    a_req = 0; b_req = 0; m_ack = 0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
